// File: rtl/pwl_pkg.sv
// Shared formats, types and the output saturation helper for the piecewise-linear evaluator.
// Input LSB is 2^-14, output LSB is 2^-16; one segment spans 2^FRAC_BITS input LSBs.
package pwl_pkg;

    localparam int IN_WIDTH    = 18;
    localparam int OUT_WIDTH   = 18;
    localparam int SLOPE_WIDTH = 18;
    localparam int SEG_BITS    = 9;
    localparam int FRAC_BITS   = 8;
    localparam int XMIN_INT    = -51472;
    localparam int XMAX_INT    = 51472;

    localparam int U_WIDTH    = SEG_BITS + FRAC_BITS;
    localparam int NSEG       = 1 << SEG_BITS;
    localparam int PROD_WIDTH = SLOPE_WIDTH + FRAC_BITS + 1;
    localparam int SUM_WIDTH  = PROD_WIDTH + 1;
    localparam int OUT_MAX    = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int OUT_MIN    = -(1 << (OUT_WIDTH - 1));

    typedef logic        [SEG_BITS-1:0]    seg_idx_t;
    typedef logic        [FRAC_BITS-1:0]   frac_t;
    typedef logic        [U_WIDTH-1:0]     u_t;
    typedef logic signed [IN_WIDTH-1:0]    in_t;
    typedef logic signed [OUT_WIDTH-1:0]   offset_t;
    typedef logic signed [SLOPE_WIDTH-1:0] slope_t;
    typedef logic signed [PROD_WIDTH-1:0]  prod_t;
    typedef logic signed [SUM_WIDTH-1:0]   sum_t;

    typedef struct packed {
        offset_t offset;
        slope_t  slope;
    } coef_t;

    localparam in_t XMIN_X = in_t'(XMIN_INT);
    localparam in_t XMAX_X = in_t'(XMAX_INT);

    function automatic offset_t sat_out(input sum_t v);
        if (v > sum_t'(OUT_MAX)) return offset_t'(OUT_MAX);
        if (v < sum_t'(OUT_MIN)) return offset_t'(OUT_MIN);
        return offset_t'(v[OUT_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/pwl_func_eval_if.sv
// Sample stream and coefficient-write port of the function evaluator.
// master = stimulus/checker controller, slave = evaluator.
interface pwl_func_eval_if;
    import pwl_pkg::*;

    logic     in_valid;
    in_t      in_;
    logic     out_valid;
    offset_t  out;
    logic     out_clip;
    logic     tbl_we;
    seg_idx_t tbl_addr;
    offset_t  tbl_offset;
    slope_t   tbl_slope;

    modport master (
        output in_valid, in_, tbl_we, tbl_addr, tbl_offset, tbl_slope,
        input  out_valid, out, out_clip
    );

    modport slave (
        input  in_valid, in_, tbl_we, tbl_addr, tbl_offset, tbl_slope,
        output out_valid, out, out_clip
    );

endinterface

// File: rtl/pwl_coef_ram.sv
// Segment coefficient store: one write port and one registered read port.
// A read and write to the same entry in one cycle returns the old entry.
module pwl_coef_ram
    import pwl_pkg::*;
(
    input  logic     clk,
    input  logic     we,
    input  seg_idx_t waddr,
    input  coef_t    wdata,
    input  seg_idx_t raddr,
    output coef_t    rdata
);

    coef_t mem [NSEG];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pwl_func_eval.sv
// Piecewise-linear evaluator y = f(clip(x)): clip/offset, table read, interpolate + saturate.
// Three register stages; no backpressure, one sample per cycle.
module pwl_func_eval
    import pwl_pkg::*;
(
    input logic           emu_clk,
    input logic           emu_rst_n,
    pwl_func_eval_if.slave bus
);

    logic    clip_d;
    u_t      u_d;
    in_t     xc;

    logic    vld_p0;
    logic    clip_p0;
    u_t      u_p0;

    logic    vld_p1;
    logic    clip_p1;
    frac_t   frac_p1;
    coef_t   coef_p1;
    offset_t offset_p1;
    slope_t  slope_p1;
    prod_t   prod_p1;
    sum_t    sum_p1;

    logic    vld_p2;
    logic    clip_p2;
    offset_t y_p2;

    // S1: clip to the table range and rebase so segment 0 starts at XMIN
    always_comb begin
        xc = bus.in_;
        if (bus.in_ < XMIN_X) begin
            xc = XMIN_X;
        end else if (bus.in_ > XMAX_X) begin
            xc = XMAX_X;
        end
        clip_d = (xc != bus.in_);
        u_d    = u_t'(xc - XMIN_X);
    end

    always_ff @(posedge emu_clk) begin
        u_p0    <= u_d;
        clip_p0 <= clip_d;
    end

    // S2: registered coefficient read; frac and clip ride alongside
    pwl_coef_ram u_coef_ram (
        .clk   (emu_clk),
        .we    (bus.tbl_we),
        .waddr (bus.tbl_addr),
        .wdata (coef_t'({bus.tbl_offset, bus.tbl_slope})),
        .raddr (u_p0[U_WIDTH-1:FRAC_BITS]),
        .rdata (coef_p1)
    );

    always_ff @(posedge emu_clk) begin
        frac_p1 <= u_p0[FRAC_BITS-1:0];
        clip_p1 <= clip_p0;
    end

    // S3: frac is unsigned, so it gets a zero sign bit before the signed multiply
    always_comb begin
        offset_p1 = coef_p1.offset;
        slope_p1  = coef_p1.slope;
        prod_p1   = prod_t'(slope_p1) * prod_t'($signed({1'b0, frac_p1}));
        sum_p1    = sum_t'(offset_p1) + sum_t'(prod_p1 >>> FRAC_BITS);
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            y_p2    <= '0;
            clip_p2 <= 1'b0;
        end else begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                y_p2    <= sat_out(sum_p1);
                clip_p2 <= clip_p1;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out       = y_p2;
    assign bus.out_clip  = clip_p2;

endmodule
